// File: rtl/capture_sched_pkg.sv
// -----------------------------------------------------------------------------
// capture_sched_pkg
//   Shared definitions for the capture scheduler:
//     - CNT_W_DEFAULT : default width of the period and watchdog counters
//     - state_t       : round sequencing state machine encoding
// -----------------------------------------------------------------------------
package capture_sched_pkg;

    localparam int CNT_W_DEFAULT = 24;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_DONE = 3'd2,
        RECOVER   = 3'd3,
        FINISH    = 3'd4
    } state_t;

endpackage : capture_sched_pkg

// File: rtl/sched_timer.sv
// -----------------------------------------------------------------------------
// sched_timer
//   Loadable wrap counter.
//
//   Ports
//     clk        : system clock, rising edge
//     reset      : asynchronous active-low reset, clears the count
//     load       : load load_value (has priority over counting)
//     load_value : value loaded while load is high
//     en         : count enable
//     limit      : wrap limit; the count runs up to limit-1 and wraps to 0.
//                  A limit of 0 never produces last.
//     count      : current count
//     last       : high while enabled and the count has reached limit-1
// -----------------------------------------------------------------------------
module sched_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         last
);

    // ">=" rather than "==" so a limit lowered below the running count still
    // wraps on the next cycle instead of running through the full range.
    assign last = en && (limit != '0) && (count >= limit - W'(1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its inputs, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en) begin
            count <= last ? '0 : count + W'(1);
        end
    end

endmodule : sched_timer

// File: rtl/capture_scheduler.sv
// -----------------------------------------------------------------------------
// capture_scheduler
//   Sequences capture rounds over two cameras. A round is started by a
//   software trigger or by the periodic trigger; each camera enabled in the
//   round mask receives one start pulse (cam0 first), and the block waits for
//   that camera's done pulse before moving on. round_done pulses at the end
//   of every round. One trigger arriving during a round is remembered and
//   serviced back-to-back; further triggers are dropped and flagged.
//
//   Build option
//     CAPTURE_SCHED_WATCHDOG_EN : adds a per-capture watchdog. When a camera
//       does not answer within timeout_cycles, it gets a one-cycle cam_reset
//       pulse, its sticky timeout bit is set and the round carries on.
//       Without the macro cam_reset and timeout are tied to 0.
//
//   Ports
//     clk                      : system clock, rising edge
//     reset                    : asynchronous active-low reset
//     enable                   : enables periodic triggering
//     period                   : cycles between periodic triggers, 0 = off
//     sw_trigger               : one-cycle software round request
//     cam_en                   : round participation mask, bit0 = cam0
//     timeout_cycles           : watchdog limit, 0 = off
//     cam0/1_frame_capture_done: camera done pulses
//     flags_clear              : clears overrun and timeout
//     cam0/1_frame_capture_start: one-cycle camera start pulses
//     cam_reset                : one-cycle per-camera recovery reset
//     busy                     : state is not IDLE
//     active_cam               : camera currently being sequenced
//     round_done               : one-cycle end-of-round pulse
//     overrun                  : sticky, a trigger was lost
//     timeout                  : sticky per-camera watchdog flags
// -----------------------------------------------------------------------------
module capture_scheduler
    import capture_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] period,
    input  logic             sw_trigger,
    input  logic [1:0]       cam_en,
    input  logic [CNT_W-1:0] timeout_cycles,
    input  logic             cam0_frame_capture_done,
    input  logic             cam1_frame_capture_done,
    input  logic             flags_clear,
    output logic             cam0_frame_capture_start,
    output logic             cam1_frame_capture_start,
    output logic [1:0]       cam_reset,
    output logic             busy,
    output logic             active_cam,
    output logic             round_done,
    output logic             overrun,
    output logic [1:0]       timeout
);

    state_t     state_q, state_d;
    logic [1:0] mask_q, mask_d;       // cameras taking part in this round
    logic [1:0] served_q, served_d;   // cameras already started this round
    logic       active_q, active_d;
    logic       pending_q, pending_d;
    logic       overrun_q;
    logic       overrun_set;

    logic       trigger;
    logic       sel_cam;
    logic [1:0] remaining;
    logic       active_done;
    logic       wd_expire;

    // ------------------------------------------------------------------
    // Periodic trigger
    // ------------------------------------------------------------------
    logic             period_run;
    logic             period_tick;
    logic [CNT_W-1:0] unused_period_count;

    // Held at 0 while disabled, so the first tick after enabling comes
    // exactly period-1 cycles later.
    assign period_run = enable && (period != '0);

    sched_timer #(.W(CNT_W)) u_period_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (!period_run),
        .load_value ('0),
        .en         (period_run),
        .limit      (period),
        .count      (unused_period_count),
        .last       (period_tick)
    );

    assign trigger = sw_trigger | period_tick;

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
`ifdef CAPTURE_SCHED_WATCHDOG_EN
    logic [CNT_W-1:0] unused_wd_count;
    logic [1:0]       timeout_q;
    logic [1:0]       timeout_set;

    // Loaded with 1 outside WAIT_DONE so the count equals the number of
    // cycles since the start pulse; expiry moves to RECOVER exactly
    // timeout_cycles cycles after the start.
    sched_timer #(.W(CNT_W)) u_watchdog (
        .clk        (clk),
        .reset      (reset),
        .load       (state_q != WAIT_DONE),
        .load_value (CNT_W'(1)),
        .en         ((state_q == WAIT_DONE) && (timeout_cycles != '0)),
        .limit      (timeout_cycles),
        .count      (unused_wd_count),
        .last       (wd_expire)
    );

    assign timeout_set = (state_q == RECOVER) ? (active_q ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_q <= 2'b00;
        end else begin
            // A set in the same cycle as flags_clear wins, per bit.
            timeout_q <= timeout_set | (flags_clear ? 2'b00 : timeout_q);
        end
    end

    assign cam_reset = timeout_set;
    assign timeout   = timeout_q;
`else
    logic unused_timeout_cycles;

    assign unused_timeout_cycles = ^timeout_cycles;
    assign wd_expire             = 1'b0;
    assign cam_reset             = 2'b00;
    assign timeout               = 2'b00;
`endif

    // ------------------------------------------------------------------
    // Round sequencing
    // ------------------------------------------------------------------
    assign remaining   = mask_q & ~served_q;
    assign sel_cam     = (mask_q[0] && !served_q[0]) ? 1'b0 : 1'b1;
    assign active_done = active_q ? cam1_frame_capture_done : cam0_frame_capture_done;

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: every control register is cleared by the async reset; there
        // is no storage array here, so nothing is left uninitialised.
        if (!reset) begin
            state_q   <= IDLE;
            mask_q    <= 2'b00;
            served_q  <= 2'b00;
            active_q  <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            served_q  <= served_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            overrun_q <= overrun_set ? 1'b1 : (flags_clear ? 1'b0 : overrun_q);
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output; a missed
        // branch would otherwise infer a latch.
        state_d     = state_q;
        mask_d      = mask_q;
        served_d    = served_q;
        active_d    = active_q;
        pending_d   = pending_q;
        overrun_set = 1'b0;

        // Triggers during a round queue one deep. FINISH consumes the
        // pending bit itself, so it is handled in its own branch below.
        if ((state_q != IDLE) && (state_q != FINISH) && trigger) begin
            if (pending_q) overrun_set = 1'b1;
            else           pending_d   = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (trigger && (cam_en != 2'b00)) begin
                    mask_d   = cam_en;
                    served_d = 2'b00;
                    state_d  = START;
                end
            end

            START: begin
                active_d          = sel_cam;
                served_d[sel_cam] = 1'b1;
                state_d           = WAIT_DONE;
            end

            WAIT_DONE: begin
                // A done pulse in the same cycle as expiry counts as done.
                if (active_done) begin
                    state_d = (remaining != 2'b00) ? START : FINISH;
                end else if (wd_expire) begin
                    state_d = RECOVER;
                end
            end

            RECOVER: begin
                state_d = (remaining != 2'b00) ? START : FINISH;
            end

            FINISH: begin
                pending_d = 1'b0;
                if (pending_q || trigger) begin
                    if (pending_q && trigger) overrun_set = 1'b1;
                    if (cam_en != 2'b00) begin
                        mask_d   = cam_en;
                        served_d = 2'b00;
                        state_d  = START;
                    end else begin
                        state_d  = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from registered state, so reset clears them at once)
    // ------------------------------------------------------------------
    assign cam0_frame_capture_start = (state_q == START) && !sel_cam;
    assign cam1_frame_capture_start = (state_q == START) &&  sel_cam;
    assign busy                     = (state_q != IDLE);
    assign round_done               = (state_q == FINISH);
    assign active_cam               = active_q;
    assign overrun                  = overrun_q;

endmodule : capture_scheduler
